mem_wr_ctrl: RTL and testbench
==============================

MEM_WR_CTRL -- requirements
Module: mem_wr_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, byte-address width; DATA_W, default 64, data width in bits (multiple of 8); LEN = DATA_W/8, derived bytes per beat.
REQ-002 ACLK  input  1  single clock; all logic on rising edge.
REQ-003 ARESETn  input  1  reset; synchronous, active-low.
REQ-004 AWADDR  input  ADDR_W  write byte address.
REQ-005 AWVALID / AWREADY  input / output  1 / 1  AXI write-address handshake.
REQ-006 WDATA  input  DATA_W  write data, byte i = WDATA[8i+7:8i].
REQ-007 WSTRB  input  LEN  byte enables.
REQ-008 WVALID / WREADY  input / output  1 / 1  write-data handshake.
REQ-009 BRESP  output  2  response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-010 BVALID / BREADY  output / input  1 / 1  response handshake.
REQ-011 mem_we  output  1  one-cycle write strobe to the byte-array memory.
REQ-012 mem_addr / mem_wdata / mem_wstrb  output  ADDR_W / DATA_W / LEN  write command to memory, valid only while mem_we=1.

Function
REQ-013 The FSM SHALL have states IDLE, WRITE and RESP; all outputs SHALL be driven from registers.
REQ-014 IDLE: AWREADY = !aw_held and WREADY = !w_held, where aw_held and w_held are single-entry holding registers.
REQ-015 An AW handshake (AWVALID & AWREADY) SHALL capture AWADDR and set aw_held; a W handshake SHALL capture WDATA/WSTRB and set w_held.
- AW and W may arrive in either order or in the same cycle.
REQ-016 IDLE -> WRITE SHALL occur on the edge where aw_held and w_held are both set after that edge's captures.
- Same-cycle AW+W at edge N: mem_we=1 during cycle N+1.
REQ-017 WRITE lasts exactly one cycle: mem_we=1 with held address, data and strobes; AWREADY=WREADY=0; then -> RESP.
REQ-018 Range check: if held address + LEN - 1 > 2**ADDR_W - 1, the write SHALL be an error.
- Error: mem_we stays 0 in WRITE; response is SLVERR; memory untouched.
- No error: BRESP=OKAY.
REQ-019 WSTRB=0 SHALL still produce the mem_we cycle with mem_wstrb=0 and return OKAY.
REQ-020 RESP: BVALID=1 with BRESP stable until BREADY=1.
- Handshake edge clears BVALID, aw_held and w_held; next state IDLE.
- AWREADY=WREADY=0 in RESP.
REQ-021 BREADY already high on entry to RESP: BVALID SHALL last exactly one cycle; minimum spacing between mem_we pulses is 3 cycles.
REQ-022 Only one write SHALL be outstanding; no new AW/W is accepted from WRITE entry until the B handshake completes.
REQ-023 mem_addr, mem_wdata and mem_wstrb SHALL be 0 whenever mem_we=0.
REQ-024 AWVALID/WVALID deasserted without a handshake SHALL have no effect; the held entries persist indefinitely in IDLE.

Reset
REQ-025 On a rising ACLK edge with ARESETn=0 the block SHALL enter IDLE and clear aw_held, w_held, BVALID, mem_we, BRESP and all mem_* outputs to 0.
- AWREADY and WREADY are 1 on the first cycle after reset release.
REQ-026 Reset asserted in WRITE or RESP SHALL abort the transaction.
- No further mem_we pulse; no BVALID for that write.
- Held entries are discarded.
REQ-027 Reset SHALL take effect only on a clock edge; asynchronous ARESETn glitches between edges SHALL have no effect.

Verification
REQ-028 Same-cycle AW+W: AWADDR=0x010, WDATA=0x0807060504030201, WSTRB=0xFF, BREADY=1 -> mem_we at N+1 with mem_addr=0x010; BVALID, BRESP=00 at N+2; AWREADY=1 at N+3.
REQ-029 W before AW: W at edge N, AW at N+3 -> WREADY=0 from N+1; mem_we at N+4; data equals the W captured at N.
REQ-030 Out of range: AWADDR=0xFFC, DATA_W=64 -> mem_we never asserted; BRESP=10, BVALID=1.
REQ-031 Backpressure: BREADY held 0 for 5 cycles -> BVALID and BRESP stable 5 cycles; AWREADY=WREADY=0 throughout; IDLE one cycle after BREADY=1.
REQ-032 Reset mid-RESP: ARESETn=0 for one edge while BVALID=1 -> next cycle BVALID=0, mem_we=0, AWREADY=WREADY=1; no response for the aborted write.
REQ-033 Partial strobe: WSTRB=0x0F, AWADDR=0x100 -> mem_wstrb=0x0F for one cycle; BRESP=00.

Source files
------------

// File: rtl/mem_wr_ctrl.sv
// mem_wr_ctrl: single-outstanding AXI-style write front end for a byte-array
// memory. AW and W are captured independently into one-entry holding
// registers. Once both are held, one memory write strobe is issued, or it is
// suppressed when the beat would run past the top of the address space. The
// write response then waits for the B handshake before the next transfer.
module mem_wr_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int LEN    = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [LEN-1:0]    WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [LEN-1:0]    mem_wstrb
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W:0] LEN_M1    = (ADDR_W + 1)'(LEN - 1);

    state_t              state_r;
    logic                aw_held_r;
    logic                w_held_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   data_r;
    logic [LEN-1:0]      strb_r;
    logic                aw_ready_r;
    logic                w_ready_r;
    logic                bvalid_r;
    logic [1:0]          bresp_r;
    logic                err_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [LEN-1:0]      mem_wstrb_r;

    logic                aw_take_s;
    logic                w_take_s;
    logic                aw_held_nx_s;
    logic                w_held_nx_s;
    logic [ADDR_W-1:0]   addr_nx_s;
    logic [DATA_W-1:0]   data_nx_s;
    logic [LEN-1:0]      strb_nx_s;
    logic [ADDR_W:0]     last_byte_s;
    logic                range_err_s;

    // Handshake detection and the holding-register contents after this edge's captures.
    always_comb begin
        aw_take_s    = 1'b0;
        w_take_s     = 1'b0;
        if (state_r == ST_IDLE) begin
            aw_take_s = AWVALID & aw_ready_r;
            w_take_s  = WVALID & w_ready_r;
        end else begin
            aw_take_s = 1'b0;
            w_take_s  = 1'b0;
        end
        aw_held_nx_s = aw_held_r | aw_take_s;
        w_held_nx_s  = w_held_r | w_take_s;
        addr_nx_s    = aw_take_s ? AWADDR : addr_r;
        data_nx_s    = w_take_s ? WDATA : data_r;
        strb_nx_s    = w_take_s ? WSTRB : strb_r;
        // The carry out of the last byte address marks a beat that wraps past the top.
        last_byte_s  = {1'b0, addr_nx_s} + LEN_M1;
        range_err_s  = last_byte_s[ADDR_W];
    end

    // Control FSM with all interface outputs registered.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r     <= ST_IDLE;
            aw_held_r   <= 1'b0;
            w_held_r    <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            strb_r      <= {LEN{1'b0}};
            aw_ready_r  <= 1'b1;
            w_ready_r   <= 1'b1;
            bvalid_r    <= 1'b0;
            bresp_r     <= RESP_OKAY;
            err_r       <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_wstrb_r <= {LEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    aw_held_r <= aw_held_nx_s;
                    w_held_r  <= w_held_nx_s;
                    addr_r    <= addr_nx_s;
                    data_r    <= data_nx_s;
                    strb_r    <= strb_nx_s;
                    if (aw_held_nx_s && w_held_nx_s) begin
                        state_r    <= ST_WRITE;
                        aw_ready_r <= 1'b0;
                        w_ready_r  <= 1'b0;
                        err_r      <= range_err_s;
                        if (!range_err_s) begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= addr_nx_s;
                            mem_wdata_r <= data_nx_s;
                            mem_wstrb_r <= strb_nx_s;
                        end else begin
                            mem_we_r    <= 1'b0;
                            mem_addr_r  <= {ADDR_W{1'b0}};
                            mem_wdata_r <= {DATA_W{1'b0}};
                            mem_wstrb_r <= {LEN{1'b0}};
                        end
                    end else begin
                        aw_ready_r <= !aw_held_nx_s;
                        w_ready_r  <= !w_held_nx_s;
                    end
                end
                ST_WRITE: begin
                    state_r     <= ST_RESP;
                    mem_we_r    <= 1'b0;
                    mem_addr_r  <= {ADDR_W{1'b0}};
                    mem_wdata_r <= {DATA_W{1'b0}};
                    mem_wstrb_r <= {LEN{1'b0}};
                    bvalid_r    <= 1'b1;
                    bresp_r     <= err_r ? RESP_SLVERR : RESP_OKAY;
                end
                ST_RESP: begin
                    if (BREADY) begin
                        state_r    <= ST_IDLE;
                        bvalid_r   <= 1'b0;
                        bresp_r    <= RESP_OKAY;
                        aw_held_r  <= 1'b0;
                        w_held_r   <= 1'b0;
                        aw_ready_r <= 1'b1;
                        w_ready_r  <= 1'b1;
                    end else begin
                        state_r    <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    aw_held_r   <= 1'b0;
                    w_held_r    <= 1'b0;
                    aw_ready_r  <= 1'b1;
                    w_ready_r   <= 1'b1;
                    bvalid_r    <= 1'b0;
                    bresp_r     <= RESP_OKAY;
                    mem_we_r    <= 1'b0;
                    mem_addr_r  <= {ADDR_W{1'b0}};
                    mem_wdata_r <= {DATA_W{1'b0}};
                    mem_wstrb_r <= {LEN{1'b0}};
                end
            endcase
        end
    end

    assign AWREADY   = aw_ready_r;
    assign WREADY    = w_ready_r;
    assign BVALID    = bvalid_r;
    assign BRESP     = bresp_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;

endmodule

// File: tb/tb_mem_wr_ctrl.sv
// Directed self-checking bench for mem_wr_ctrl (ADDR_W=12, DATA_W=64).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_wr_ctrl;

    logic        ACLK;
    logic        ARESETn;
    logic [11:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;

    int n_checks;
    int n_errors;

    mem_wr_ctrl #(.ADDR_W(12), .DATA_W(64)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    // Free-running clock, period 10.
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Present AW and W together for one edge, then drop both valids.
    task automatic send_both(input logic [11:0] a, input logic [63:0] d, input logic [7:0] s);
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        ARESETn = 1'b0; AWADDR = 12'h0; AWVALID = 1'b0; WDATA = 64'h0;
        WSTRB = 8'h0; WVALID = 1'b0; BREADY = 1'b1;
        tick(); tick();
        ARESETn = 1'b1;
        check("rst_awready", AWREADY, 64'h1);
        check("rst_wready", WREADY, 64'h1);
        check("rst_bvalid", BVALID, 64'h0);
        check("rst_mem_we", mem_we, 64'h0);
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_bresp", BRESP, 64'h0);

        // Same-cycle AW+W, BREADY already high.
        send_both(12'h010, 64'h0807060504030201, 8'hFF);
        check("sc_mem_we", mem_we, 64'h1);
        check("sc_mem_addr", mem_addr, 64'h010);
        check("sc_mem_wdata", mem_wdata, 64'h0807060504030201);
        check("sc_mem_wstrb", mem_wstrb, 64'hFF);
        check("sc_awready_w", AWREADY, 64'h0);
        check("sc_wready_w", WREADY, 64'h0);
        tick();
        check("sc_mem_we_off", mem_we, 64'h0);
        check("sc_mem_addr_0", mem_addr, 64'h0);
        check("sc_mem_wdata_0", mem_wdata, 64'h0);
        check("sc_bvalid", BVALID, 64'h1);
        check("sc_bresp", BRESP, 64'h0);
        tick();
        check("sc_bvalid_1cyc", BVALID, 64'h0);
        check("sc_awready_back", AWREADY, 64'h1);
        check("sc_wready_back", WREADY, 64'h1);

        // W first, AW three edges later; late W data must not be taken.
        WDATA = 64'hA5A5_0000_1234_5678; WSTRB = 8'h3C; WVALID = 1'b1;
        tick();
        WVALID = 1'b0; WDATA = 64'hDEAD_BEEF_DEAD_BEEF;
        check("wf_wready_0", WREADY, 64'h0);
        check("wf_awready_1", AWREADY, 64'h1);
        check("wf_no_we", mem_we, 64'h0);
        tick(); tick();
        check("wf_wready_hold", WREADY, 64'h0);
        AWADDR = 12'h200; AWVALID = 1'b1; WVALID = 1'b1; WSTRB = 8'hFF;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        check("wf_mem_we", mem_we, 64'h1);
        check("wf_mem_addr", mem_addr, 64'h200);
        check("wf_mem_wdata", mem_wdata, 64'hA5A5_0000_1234_5678);
        check("wf_mem_wstrb", mem_wstrb, 64'h3C);
        tick(); tick();

        // AW first, W later, with an all-zero strobe.
        AWADDR = 12'h300; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("af_awready_0", AWREADY, 64'h0);
        check("af_wready_1", WREADY, 64'h1);
        check("af_no_we", mem_we, 64'h0);
        WDATA = 64'h1111_2222_3333_4444; WSTRB = 8'h00; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("z_mem_we", mem_we, 64'h1);
        check("z_mem_wstrb", mem_wstrb, 64'h0);
        check("z_mem_addr", mem_addr, 64'h300);
        tick();
        check("z_bresp", BRESP, 64'h0);
        check("z_bvalid", BVALID, 64'h1);
        tick();

        // Out of range: 0xFFC + 7 > 0xFFF.
        send_both(12'hFFC, 64'h0123_4567_89AB_CDEF, 8'hFF);
        check("oor_no_we", mem_we, 64'h0);
        check("oor_mem_addr_0", mem_addr, 64'h0);
        check("oor_awready_0", AWREADY, 64'h0);
        tick();
        check("oor_no_we2", mem_we, 64'h0);
        check("oor_bvalid", BVALID, 64'h1);
        check("oor_bresp", BRESP, 64'h2);
        tick();
        check("oor_bvalid_done", BVALID, 64'h0);

        // Top in-range beat: 0xFF8 + 7 = 0xFFF.
        send_both(12'hFF8, 64'hFEED_FACE_CAFE_F00D, 8'h81);
        check("edge_mem_we", mem_we, 64'h1);
        check("edge_mem_addr", mem_addr, 64'hFF8);
        tick();
        check("edge_bresp", BRESP, 64'h0);
        tick();

        // Backpressure: BREADY low 5 cycles, AWVALID/WVALID pushing meanwhile.
        BREADY = 1'b0;
        send_both(12'h040, 64'h5555_AAAA_5555_AAAA, 8'hF0);
        check("bp_mem_we", mem_we, 64'h1);
        tick();
        AWADDR = 12'h7F0; AWVALID = 1'b1; WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_bvalid_%0d", i), BVALID, 64'h1);
            check($sformatf("bp_bresp_%0d", i), BRESP, 64'h0);
            check($sformatf("bp_awready_%0d", i), AWREADY, 64'h0);
            check($sformatf("bp_wready_%0d", i), WREADY, 64'h0);
            check($sformatf("bp_mem_we_%0d", i), mem_we, 64'h0);
            if (i == 2) begin
                // Reset glitch between edges must be ignored.
                ARESETn = 1'b0; #2; ARESETn = 1'b1;
            end
            tick();
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        BREADY = 1'b1;
        check("bp_bvalid_last", BVALID, 64'h1);
        tick();
        check("bp_bvalid_clr", BVALID, 64'h0);
        check("bp_awready_idle", AWREADY, 64'h1);
        check("bp_wready_idle", WREADY, 64'h1);

        // Reset while BVALID=1 aborts the write.
        BREADY = 1'b0;
        send_both(12'h080, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF);
        check("rr_mem_we", mem_we, 64'h1);
        tick();
        check("rr_bvalid_pre", BVALID, 64'h1);
        ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1;
        check("rr_bvalid", BVALID, 64'h0);
        check("rr_mem_we", mem_we, 64'h0);
        check("rr_awready", AWREADY, 64'h1);
        check("rr_wready", WREADY, 64'h1);
        BREADY = 1'b1;
        tick();
        check("rr_no_resp", BVALID, 64'h0);
        // Held W from the aborted write must be gone: AW alone does not write.
        AWADDR = 12'h0A0; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("rr_aw_only_no_we", mem_we, 64'h0);
        tick();
        check("rr_still_no_we", mem_we, 64'h0);
        check("rr_wready_open", WREADY, 64'h1);
        WDATA = 64'h7777_6666_5555_4444; WSTRB = 8'hFF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("rr_new_we", mem_we, 64'h1);
        check("rr_new_addr", mem_addr, 64'h0A0);
        tick(); tick();

        // Partial strobe.
        send_both(12'h100, 64'hCCCC_DDDD_EEEE_FFFF, 8'h0F);
        check("ps_mem_we", mem_we, 64'h1);
        check("ps_mem_wstrb", mem_wstrb, 64'h0F);
        tick();
        check("ps_mem_we_off", mem_we, 64'h0);
        check("ps_mem_wstrb_0", mem_wstrb, 64'h0);
        check("ps_bresp", BRESP, 64'h0);
        check("ps_bvalid", BVALID, 64'h1);
        tick();
        check("ps_idle", AWREADY, 64'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
